cell_unit: RTL and testbench
============================

CELL_UNIT -- requirements
Module: cell_unit

Interface
REQ-001 Parameter DATA_WIDTH, default 8, activation and weight width in bits.
REQ-002 Parameter BLOCK_WIDTH, default 4, width of the mask index and number of output lanes.
REQ-003 Parameter BLOCK_NUMBER, default 16, number of activations per input vector.
REQ-004 The accumulator width SHALL be fixed at 4*DATA_WIDTH (32 bits).
REQ-005 Clk1  in  1  the single clock; all state updates on the rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 Input_act_data  in  BLOCK_NUMBER*DATA_WIDTH  activation vector; act[i] = bits [8i+7:8i].
REQ-008 Input_weight  in  DATA_WIDTH  current nonzero weight, signed two's complement.
REQ-009 mask  in  BLOCK_WIDTH  sparse index of the activation paired with the weight.
REQ-010 Block_control  in  1  MAC valid for this cycle.
REQ-011 Control  in  1  accumulate enable.
REQ-012 Direction  in  1  lane offset direction: 0 = +k, 1 = -k.
REQ-013 ResultCapture  in  1  active-low load of the partial sums ResultIn_0..3.
REQ-014 ResultIn_0..ResultIn_3  in  32 each  incoming partial sums, one per lane.
REQ-015 Cell_Output_data_0..Cell_Output_data_3  out  32 each  registered lane accumulators.

Function
REQ-016 Lane k (k = 0..3) SHALL select act[(mask + k) mod 16] when Direction=0, and act[(mask - k) mod 16] when Direction=1; the index wraps modulo 16.
REQ-017 Lane k product SHALL be signed(act) * signed(Input_weight), 16 bits, sign-extended to 32 bits.
REQ-018 Accumulation SHALL be 32-bit two's complement, wrapping modulo 2^32, with no saturation.
REQ-019 Per rising edge, when rst=0, the update priority SHALL be:
- (a) ResultCapture=0: acc_k <= ResultIn_k;
- (b) else if Control=1 and Block_control=1: acc_k <= acc_k + product_k;
- (c) else: acc_k holds.
REQ-020 When ResultCapture=0 coincides with Control=1 and Block_control=1, the load SHALL win and the product SHALL be discarded.
REQ-021 Cell_Output_data_k SHALL equal acc_k directly; a product is visible one cycle after its inputs are sampled.
REQ-022 All four lanes SHALL update in the same cycle, using the same weight, mask and Direction.
REQ-023 Inputs are sampled only at the clock edge; mask and activation changes between edges SHALL have no effect.

Reset
REQ-024 While rst=1, all four accumulators, and therefore all outputs, SHALL be 0, asynchronously and regardless of the clock.
REQ-025 Asserting rst mid-accumulation SHALL clear the state immediately; after deassertion, the first edge follows REQ-019.

Structure
REQ-026 DATA_WIDTH, BLOCK_WIDTH, BLOCK_NUMBER and ACC_WIDTH=32 SHALL live in a shared package cell_pkg.
REQ-027 One sub-module, cell_pe (one lane: index mux, signed multiply, accumulator register, load/hold logic), SHALL be instantiated four times with lane offset k as a parameter.
REQ-028 cell_unit SHALL contain only the lane instantiation and port mapping; there is no FSM.

Verification
Common stimulus for REQ-029 to REQ-034: act[0]=16, act[i]=i for i=1..15; Input_weight=1 unless stated.
REQ-029 rst=1 -> all outputs 0 immediately, with no clock edge required.
REQ-030 ResultCapture=0, ResultIn=40/50/60/70 for one edge -> outputs 40/50/60/70.
REQ-031 Control=1, Block_control=1, Direction=0, mask=2 on one edge after REQ-030 -> outputs 42/53/64/75.
REQ-032 Direction=1, mask=1 from the REQ-030 state -> lanes add 1/16/15/14 (mod-16 wrap) -> outputs 41/66/75/84.
REQ-033 Block_control=0 or Control=0 for 3 edges -> outputs unchanged.
REQ-034 Signed and wrap arithmetic:
- Input_weight=0xFF, mask=3, acc=40 -> lane0 output 37.
- acc=0xFFFFFFFF plus product 1 -> output 0.
- ResultCapture=0 together with Control=1 -> load value only.

Source files
------------

// File: rtl/cell_pkg.sv
// Shared widths for the sparse MAC cell: activation/weight width, mask/lane
// geometry and the fixed 32-bit accumulator width.
package cell_pkg;

    localparam int unsigned DATA_WIDTH   = 8;
    localparam int unsigned BLOCK_WIDTH  = 4;
    localparam int unsigned BLOCK_NUMBER = 16;
    localparam int unsigned ACC_WIDTH    = 4 * DATA_WIDTH;
    localparam int unsigned NUM_LANES    = 4;

endpackage : cell_pkg

// File: rtl/cell_pe.sv
// One MAC lane: picks act[(mask +/- LANE) mod BLOCK_NUMBER], multiplies it
// by the signed weight and accumulates into a 32-bit wrapping register.
// Ports:
//   clk_i, rst_i  clock, async active-high reset
//   act_i         packed activation vector, act[i] = bits [DW*i +: DW]
//   weight_i      signed weight
//   mask_i        base activation index
//   valid_i       MAC valid (Block_control)
//   enable_i      accumulate enable (Control)
//   dir_i         0: index = mask + LANE, 1: index = mask - LANE
//   load_n_i      active-low load of load_val_i into the accumulator
//   load_val_i    partial sum to load
//   acc_o         accumulator register
module cell_pe
    import cell_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = cell_pkg::DATA_WIDTH,
    parameter int unsigned BLOCK_WIDTH  = cell_pkg::BLOCK_WIDTH,
    parameter int unsigned BLOCK_NUMBER = cell_pkg::BLOCK_NUMBER,
    parameter int unsigned LANE         = 0
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic [BLOCK_NUMBER*DATA_WIDTH-1:0] act_i,
    input  logic [DATA_WIDTH-1:0]              weight_i,
    input  logic [BLOCK_WIDTH-1:0]             mask_i,
    input  logic                               valid_i,
    input  logic                               enable_i,
    input  logic                               dir_i,
    input  logic                               load_n_i,
    input  logic [ACC_WIDTH-1:0]               load_val_i,
    output logic [ACC_WIDTH-1:0]               acc_o
);

    localparam int unsigned PROD_WIDTH = 2 * DATA_WIDTH;
    localparam logic [BLOCK_WIDTH-1:0] OFFSET = BLOCK_WIDTH'(LANE);

    logic [DATA_WIDTH-1:0]        act_arr [BLOCK_NUMBER];
    logic [BLOCK_WIDTH-1:0]       idx_c;
    logic [DATA_WIDTH-1:0]        act_sel_c;
    logic signed [PROD_WIDTH-1:0] prod_c;
    logic [ACC_WIDTH-1:0]         prod_ext_c;
    logic [ACC_WIDTH-1:0]         acc_d;
    logic [ACC_WIDTH-1:0]         acc_q;

    // Unpack the activation vector into addressable entries.
    for (genvar i = 0; i < BLOCK_NUMBER; i++) begin : g_unpack
        assign act_arr[i] = act_i[i*DATA_WIDTH +: DATA_WIDTH];
    end

    // Index arithmetic in BLOCK_WIDTH bits wraps modulo BLOCK_NUMBER.
    always_comb begin
        idx_c      = dir_i ? (mask_i - OFFSET) : (mask_i + OFFSET);
        act_sel_c  = act_arr[idx_c];
        prod_c     = $signed(act_sel_c) * $signed(weight_i);
        prod_ext_c = {{(ACC_WIDTH-PROD_WIDTH){prod_c[PROD_WIDTH-1]}}, prod_c};
    end

    // Load beats accumulate; otherwise hold.
    always_comb begin
        acc_d = acc_q;
        if (!load_n_i) begin
            acc_d = load_val_i;
        end else if (enable_i && valid_i) begin
            acc_d = acc_q + prod_ext_c;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_o = acc_q;

endmodule : cell_pe

// File: rtl/cell_unit.sv
// Four-lane sparse MAC cell: every lane shares weight, mask and direction and
// reads a neighbouring activation offset by its lane number.
// Ports:
//   Clk1, rst                          clock, async active-high reset
//   Input_act_data                     BLOCK_NUMBER packed activations
//   Input_weight                       signed weight
//   mask                               base activation index
//   Block_control, Control             MAC valid / accumulate enable
//   Direction                          0: +k lane offset, 1: -k
//   ResultCapture                      active-low load of ResultIn_0..3
//   ResultIn_0..3                      partial sums to load
//   Cell_Output_data_0..3              lane accumulators
module cell_unit
    import cell_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = cell_pkg::DATA_WIDTH,
    parameter int unsigned BLOCK_WIDTH  = cell_pkg::BLOCK_WIDTH,
    parameter int unsigned BLOCK_NUMBER = cell_pkg::BLOCK_NUMBER
) (
    input  logic                               Clk1,
    input  logic                               rst,
    input  logic [BLOCK_NUMBER*DATA_WIDTH-1:0] Input_act_data,
    input  logic [DATA_WIDTH-1:0]              Input_weight,
    input  logic [BLOCK_WIDTH-1:0]             mask,
    input  logic                               Block_control,
    input  logic                               Control,
    input  logic                               Direction,
    input  logic                               ResultCapture,
    input  logic [ACC_WIDTH-1:0]               ResultIn_0,
    input  logic [ACC_WIDTH-1:0]               ResultIn_1,
    input  logic [ACC_WIDTH-1:0]               ResultIn_2,
    input  logic [ACC_WIDTH-1:0]               ResultIn_3,
    output logic [ACC_WIDTH-1:0]               Cell_Output_data_0,
    output logic [ACC_WIDTH-1:0]               Cell_Output_data_1,
    output logic [ACC_WIDTH-1:0]               Cell_Output_data_2,
    output logic [ACC_WIDTH-1:0]               Cell_Output_data_3
);

    logic [ACC_WIDTH-1:0] lane_in  [NUM_LANES];
    logic [ACC_WIDTH-1:0] lane_out [NUM_LANES];

    assign lane_in[0] = ResultIn_0;
    assign lane_in[1] = ResultIn_1;
    assign lane_in[2] = ResultIn_2;
    assign lane_in[3] = ResultIn_3;

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        cell_pe #(
            .DATA_WIDTH  (DATA_WIDTH),
            .BLOCK_WIDTH (BLOCK_WIDTH),
            .BLOCK_NUMBER(BLOCK_NUMBER),
            .LANE        (k)
        ) u_pe (
            .clk_i      (Clk1),
            .rst_i      (rst),
            .act_i      (Input_act_data),
            .weight_i   (Input_weight),
            .mask_i     (mask),
            .valid_i    (Block_control),
            .enable_i   (Control),
            .dir_i      (Direction),
            .load_n_i   (ResultCapture),
            .load_val_i (lane_in[k]),
            .acc_o      (lane_out[k])
        );
    end

    assign Cell_Output_data_0 = lane_out[0];
    assign Cell_Output_data_1 = lane_out[1];
    assign Cell_Output_data_2 = lane_out[2];
    assign Cell_Output_data_3 = lane_out[3];

endmodule : cell_unit

// File: tb/tb_cell_unit.sv
// Directed bench for cell_unit: load, both lane directions with wrap, hold,
// signed/wrapping arithmetic, load priority and asynchronous reset.
module tb_cell_unit;

    logic         Clk1 = 1'b0;
    logic         rst  = 1'b0;
    logic [127:0] Input_act_data;
    logic [7:0]   Input_weight;
    logic [3:0]   mask;
    logic         Block_control;
    logic         Control;
    logic         Direction;
    logic         ResultCapture;
    logic [31:0]  ResultIn_0, ResultIn_1, ResultIn_2, ResultIn_3;
    logic [31:0]  Cell_Output_data_0, Cell_Output_data_1;
    logic [31:0]  Cell_Output_data_2, Cell_Output_data_3;
    logic [31:0]  out_w [4];

    int n_tests = 0;
    int n_fail  = 0;

    cell_unit dut (
        .Clk1              (Clk1),
        .rst               (rst),
        .Input_act_data    (Input_act_data),
        .Input_weight      (Input_weight),
        .mask              (mask),
        .Block_control     (Block_control),
        .Control           (Control),
        .Direction         (Direction),
        .ResultCapture     (ResultCapture),
        .ResultIn_0        (ResultIn_0),
        .ResultIn_1        (ResultIn_1),
        .ResultIn_2        (ResultIn_2),
        .ResultIn_3        (ResultIn_3),
        .Cell_Output_data_0(Cell_Output_data_0),
        .Cell_Output_data_1(Cell_Output_data_1),
        .Cell_Output_data_2(Cell_Output_data_2),
        .Cell_Output_data_3(Cell_Output_data_3)
    );

    always #5 Clk1 = ~Clk1;

    assign out_w[0] = Cell_Output_data_0;
    assign out_w[1] = Cell_Output_data_1;
    assign out_w[2] = Cell_Output_data_2;
    assign out_w[3] = Cell_Output_data_3;

    // One rising edge, then settle 1ns past it.
    task automatic tick();
        @(posedge Clk1);
        #1;
    endtask

    task automatic set_act_default();
        Input_act_data[7:0] = 8'd16;
        for (int i = 1; i < 16; i++) Input_act_data[i*8 +: 8] = 8'(i);
    endtask

    task automatic idle_inputs();
        Input_weight  = 8'd1;
        mask          = 4'd0;
        Block_control = 1'b0;
        Control       = 1'b0;
        Direction     = 1'b0;
        ResultCapture = 1'b1;
    endtask

    task automatic load(input logic [31:0] v0, input logic [31:0] v1,
                        input logic [31:0] v2, input logic [31:0] v3);
        ResultIn_0 = v0; ResultIn_1 = v1; ResultIn_2 = v2; ResultIn_3 = v3;
        ResultCapture = 1'b0;
        tick();
        ResultCapture = 1'b1;
    endtask

    task automatic mac(input logic [7:0] w, input logic [3:0] m, input logic d);
        Input_weight  = w;
        mask          = m;
        Direction     = d;
        Control       = 1'b1;
        Block_control = 1'b1;
        tick();
        Control       = 1'b0;
        Block_control = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] exp [4];
        exp = '{32'd0, 32'd0, 32'd0, 32'd0};
        #2 rst = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            n_tests++;
            if (out_w[k] !== exp[k]) begin
                n_fail++;
                $display("FAIL reset lane%0d: got %0h expected %0h", k, out_w[k], exp[k]);
            end
        end
        tick();
        #2 rst = 1'b0;
    endtask

    task automatic test_load();
        logic [31:0] exp [4];
        exp = '{32'd40, 32'd50, 32'd60, 32'd70};
        load(32'd40, 32'd50, 32'd60, 32'd70);
        for (int k = 0; k < 4; k++) begin
            n_tests++;
            if (out_w[k] !== exp[k]) begin
                n_fail++;
                $display("FAIL load lane%0d: got %0d expected %0d", k, out_w[k], exp[k]);
            end
        end
    endtask

    task automatic test_dir_plus();
        logic [31:0] exp [4];
        exp = '{32'd42, 32'd53, 32'd64, 32'd75};
        load(32'd40, 32'd50, 32'd60, 32'd70);
        mac(8'd1, 4'd2, 1'b0);
        for (int k = 0; k < 4; k++) begin
            n_tests++;
            if (out_w[k] !== exp[k]) begin
                n_fail++;
                $display("FAIL dir_plus lane%0d: got %0d expected %0d", k, out_w[k], exp[k]);
            end
        end
    endtask

    task automatic test_dir_minus_wrap();
        logic [31:0] exp [4];
        exp = '{32'd41, 32'd66, 32'd75, 32'd84};
        load(32'd40, 32'd50, 32'd60, 32'd70);
        mac(8'd1, 4'd1, 1'b1);
        for (int k = 0; k < 4; k++) begin
            n_tests++;
            if (out_w[k] !== exp[k]) begin
                n_fail++;
                $display("FAIL dir_minus lane%0d: got %0d expected %0d", k, out_w[k], exp[k]);
            end
        end
    endtask

    // Three edges with only one or neither enable high, plus a between-edge
    // input change, must all leave the accumulators untouched.
    task automatic test_hold();
        logic [31:0] exp [4];
        exp = '{32'd41, 32'd66, 32'd75, 32'd84};
        Input_weight = 8'd3; mask = 4'd5;
        Control = 1'b1; Block_control = 1'b0; tick();
        Control = 1'b0; Block_control = 1'b1; tick();
        Control = 1'b0; Block_control = 1'b0; tick();
        mask = 4'd9; Control = 1'b1; Block_control = 1'b1;
        #2;
        for (int k = 0; k < 4; k++) begin
            n_tests++;
            if (out_w[k] !== exp[k]) begin
                n_fail++;
                $display("FAIL hold lane%0d: got %0d expected %0d", k, out_w[k], exp[k]);
            end
        end
        Control = 1'b0; Block_control = 1'b0;
        tick();
    endtask

    task automatic test_signed_weight();
        logic [31:0] exp [4];
        exp = '{32'd37, 32'd46, 32'd55, 32'd64};
        load(32'd40, 32'd50, 32'd60, 32'd70);
        mac(8'hFF, 4'd3, 1'b0);
        for (int k = 0; k < 4; k++) begin
            n_tests++;
            if (out_w[k] !== exp[k]) begin
                n_fail++;
                $display("FAIL signed_weight lane%0d: got %0d expected %0d", k, out_w[k], exp[k]);
            end
        end
    endtask

    // act[5] = -128 with weight -128 gives +16384; neighbours give negatives.
    task automatic test_signed_act();
        logic [31:0] exp [4];
        exp = '{32'h0000_4000, 32'hFFFF_FD00, 32'hFFFF_FC80, 32'hFFFF_FC00};
        Input_act_data[5*8 +: 8] = 8'h80;
        load(32'd0, 32'd0, 32'd0, 32'd0);
        mac(8'h80, 4'd5, 1'b0);
        for (int k = 0; k < 4; k++) begin
            n_tests++;
            if (out_w[k] !== exp[k]) begin
                n_fail++;
                $display("FAIL signed_act lane%0d: got %0h expected %0h", k, out_w[k], exp[k]);
            end
        end
        set_act_default();
    endtask

    task automatic test_wrap();
        logic [31:0] exp [4];
        exp = '{32'd0, 32'd1, 32'd2, 32'd3};
        load(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        mac(8'd1, 4'd1, 1'b0);
        for (int k = 0; k < 4; k++) begin
            n_tests++;
            if (out_w[k] !== exp[k]) begin
                n_fail++;
                $display("FAIL wrap lane%0d: got %0h expected %0h", k, out_w[k], exp[k]);
            end
        end
    endtask

    task automatic test_load_priority();
        logic [31:0] exp [4];
        exp = '{32'd1, 32'd2, 32'd3, 32'd4};
        ResultIn_0 = 32'd1; ResultIn_1 = 32'd2; ResultIn_2 = 32'd3; ResultIn_3 = 32'd4;
        Input_weight = 8'd7; mask = 4'd6; Direction = 1'b0;
        ResultCapture = 1'b0; Control = 1'b1; Block_control = 1'b1;
        tick();
        ResultCapture = 1'b1; Control = 1'b0; Block_control = 1'b0;
        for (int k = 0; k < 4; k++) begin
            n_tests++;
            if (out_w[k] !== exp[k]) begin
                n_fail++;
                $display("FAIL load_priority lane%0d: got %0d expected %0d", k, out_w[k], exp[k]);
            end
        end
    endtask

    // Reset between edges clears at once; the first edge after release MACs from 0.
    task automatic test_async_reset();
        logic [31:0] exp0 [4];
        logic [31:0] exp1 [4];
        exp0 = '{32'd0, 32'd0, 32'd0, 32'd0};
        exp1 = '{32'd2, 32'd3, 32'd4, 32'd5};
        load(32'd100, 32'd200, 32'd300, 32'd400);
        #2 rst = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            n_tests++;
            if (out_w[k] !== exp0[k]) begin
                n_fail++;
                $display("FAIL async_reset lane%0d: got %0d expected %0d", k, out_w[k], exp0[k]);
            end
        end
        rst = 1'b0;
        mac(8'd1, 4'd2, 1'b0);
        for (int k = 0; k < 4; k++) begin
            n_tests++;
            if (out_w[k] !== exp1[k]) begin
                n_fail++;
                $display("FAIL post_reset_mac lane%0d: got %0d expected %0d", k, out_w[k], exp1[k]);
            end
        end
    endtask

    initial begin
        set_act_default();
        idle_inputs();
        ResultIn_0 = '0; ResultIn_1 = '0; ResultIn_2 = '0; ResultIn_3 = '0;
        test_reset();
        test_load();
        test_dir_plus();
        test_dir_minus_wrap();
        test_hold();
        test_signed_weight();
        test_signed_act();
        test_wrap();
        test_load_priority();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_cell_unit
